unidad_control: RTL and testbench

Multi-cycle control unit that drives the combinational ALU: it fetches 32-bit instructions from a shared memory port, decodes them, presents `opcode` to the ALU, writes back `resultado`, and latches the C/S/O/Z flags for conditional jumps. It sits between the instruction/data memory, the register file and the ALU, as the issuing end of the ALU opcode/flags interface.

---
 rtl/unidad_control_pkg.sv | 70 +++++++
 rtl/unidad_control_decodificador_instr.sv | 50 +++++
 rtl/unidad_control.sv | 247 ++++++++++++++++++++++++
 tb/tb_unidad_control.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidad_control_pkg.sv
// unidad_control shared definitions: opcodes, instruction layout,
// FSM states and decoded instruction classes.
package unidad_control_pkg;

  // ALU opcodes (shared with the ALU)
  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_NOT = 5'h01;
  localparam logic [4:0] OP_AND = 5'h02;
  localparam logic [4:0] OP_OR  = 5'h03;
  localparam logic [4:0] OP_XOR = 5'h04;
  localparam logic [4:0] OP_NEG = 5'h05;
  localparam logic [4:0] OP_ADD = 5'h06;
  localparam logic [4:0] OP_SUB = 5'h07;
  localparam logic [4:0] OP_MUL = 5'h08;
  localparam logic [4:0] OP_DIV = 5'h09;
  localparam logic [4:0] OP_MOD = 5'h0A;

  // Control-flow and memory opcodes
  localparam logic [4:0] OP_JMP = 5'h10;
  localparam logic [4:0] OP_JC  = 5'h11;
  localparam logic [4:0] OP_JS  = 5'h12;
  localparam logic [4:0] OP_JO  = 5'h13;
  localparam logic [4:0] OP_JZ  = 5'h14;
  localparam logic [4:0] OP_LD  = 5'h18;
  localparam logic [4:0] OP_STR = 5'h19;
  localparam logic [4:0] OP_HLT = 5'h1F;

  // Instruction layout, MSB first:
  // op[31:27] rd[26:23] ra[22:19] rb[18:15] imm[14:0]
  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [14:0] imm;
  } instr_t;

  typedef enum logic [2:0] {
    EST_FETCH,
    EST_DECODE,
    EST_EXECUTE,
    EST_MEM,
    EST_HALT
  } estado_e;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_SALTO,
    CL_MEM_LD,
    CL_MEM_ST,
    CL_NOP,
    CL_HLT,
    CL_ILEGAL
  } clase_e;

  // Bit index of each flag inside banderas = {C,S,O,Z}
  localparam logic [1:0] SEL_Z = 2'd0;
  localparam logic [1:0] SEL_O = 2'd1;
  localparam logic [1:0] SEL_S = 2'd2;
  localparam logic [1:0] SEL_C = 2'd3;

  // ALU operations this unit actually issues
  function automatic logic es_op_alu(
    input logic [4:0] op
  );
    return op inside {OP_NOT, OP_AND, OP_OR,
                      OP_NEG, OP_ADD, OP_SUB};
  endfunction

endpackage

// File: rtl/unidad_control_decodificador_instr.sv
// decodificador_instr: combinational opcode classifier
// plus flag select for conditional jumps.
module decodificador_instr
  import unidad_control_pkg::*;
(
  input  logic [4:0] i_opcode,
  output clase_e     o_clase,
  output logic [1:0] o_sel_bandera,
  output logic       o_incond
);

  // One-hot style classification; anything unmatched is illegal
  always_comb begin
    o_clase       = CL_ILEGAL;
    o_sel_bandera = SEL_Z;
    o_incond      = 1'b0;
    unique case (1'b1)
      es_op_alu(i_opcode): o_clase = CL_ALU;
      (i_opcode inside {OP_XOR, OP_MUL,
                        OP_DIV, OP_MOD}):
        o_clase = CL_ILEGAL;
      (i_opcode == OP_JMP): begin
        o_clase  = CL_SALTO;
        o_incond = 1'b1;
      end
      (i_opcode == OP_JC): begin
        o_clase       = CL_SALTO;
        o_sel_bandera = SEL_C;
      end
      (i_opcode == OP_JS): begin
        o_clase       = CL_SALTO;
        o_sel_bandera = SEL_S;
      end
      (i_opcode == OP_JO): begin
        o_clase       = CL_SALTO;
        o_sel_bandera = SEL_O;
      end
      (i_opcode == OP_JZ): begin
        o_clase       = CL_SALTO;
        o_sel_bandera = SEL_Z;
      end
      (i_opcode == OP_LD):  o_clase = CL_MEM_LD;
      (i_opcode == OP_STR): o_clase = CL_MEM_ST;
      (i_opcode == OP_NOP): o_clase = CL_NOP;
      (i_opcode == OP_HLT): o_clase = CL_HLT;
      default:              o_clase = CL_ILEGAL;
    endcase
  end

endmodule

// File: rtl/unidad_control.sv
// unidad_control: multi-cycle FETCH/DECODE/EXECUTE/MEM/HALT
// sequencer issuing ALU opcodes and handling memory + jumps.
module unidad_control
  import unidad_control_pkg::*;
#(
  parameter int                   BITS_DATA = 32,
  parameter int                   ANCHO_DIR = 16,
  parameter logic [ANCHO_DIR-1:0] PC_INICIO = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ANCHO_DIR-1:0] mem_addr,
  output logic [BITS_DATA-1:0] mem_wdata,
  input  logic [BITS_DATA-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [3:0]           rf_dir_a,
  output logic [3:0]           rf_dir_b,
  input  logic [BITS_DATA-1:0] rf_dato_a,
  output logic                 rf_we,
  output logic [3:0]           rf_dir_w,
  output logic [BITS_DATA-1:0] rf_dato_w,
  output logic [4:0]           alu_opcode,
  input  logic [BITS_DATA-1:0] alu_resultado,
  input  logic                 alu_C,
  input  logic                 alu_S,
  input  logic                 alu_O,
  input  logic                 alu_Z,
  output logic [3:0]           banderas,
  output logic [ANCHO_DIR-1:0] pc,
  output logic                 detenido,
  output logic                 ilegal
);

  estado_e              r_estado;
  estado_e              w_estado_sig;
  instr_t               r_ir;
  instr_t               w_ir_sig;
  logic [ANCHO_DIR-1:0] r_pc;
  logic [ANCHO_DIR-1:0] w_pc_sig;
  logic [3:0]           r_banderas;
  logic [3:0]           w_banderas_sig;
  logic                 r_mem_req;
  logic                 w_mem_req_sig;
  logic                 r_mem_we;
  logic                 w_mem_we_sig;
  logic [ANCHO_DIR-1:0] r_mem_addr;
  logic [ANCHO_DIR-1:0] w_mem_addr_sig;
  logic [BITS_DATA-1:0] r_mem_wdata;
  logic [BITS_DATA-1:0] w_mem_wdata_sig;
  logic [3:0]           r_rf_dir_a;
  logic [3:0]           w_rf_dir_a_sig;
  logic [3:0]           r_rf_dir_b;
  logic [3:0]           w_rf_dir_b_sig;
  logic                 r_rf_we;
  logic                 w_rf_we_sig;
  logic [3:0]           r_rf_dir_w;
  logic [3:0]           w_rf_dir_w_sig;
  logic [BITS_DATA-1:0] r_rf_dato_w;
  logic [BITS_DATA-1:0] w_rf_dato_w_sig;
  logic [4:0]           r_alu_opcode;
  logic [4:0]           w_alu_opcode_sig;
  logic                 r_detenido;
  logic                 w_detenido_sig;
  logic                 r_ilegal;
  logic                 w_ilegal_sig;

  clase_e               w_clase;
  logic [1:0]           w_sel;
  logic                 w_incond;
  logic [ANCHO_DIR-1:0] w_imm_ext;
  logic [ANCHO_DIR-1:0] w_pc_mas1;

  decodificador_instr u_dec (
    .i_opcode      (r_ir.op),
    .o_clase       (w_clase),
    .o_sel_bandera (w_sel),
    .o_incond      (w_incond)
  );

  assign w_imm_ext = ANCHO_DIR'(r_ir.imm);
  assign w_pc_mas1 = r_pc + ANCHO_DIR'(1);

  // Next state and next registered outputs; all outputs are
  // registered so reset and request timing stay glitch-free
  always_comb begin
    w_estado_sig     = r_estado;
    w_ir_sig         = r_ir;
    w_pc_sig         = r_pc;
    w_banderas_sig   = r_banderas;
    w_mem_req_sig    = r_mem_req;
    w_mem_we_sig     = r_mem_we;
    w_mem_addr_sig   = r_mem_addr;
    w_mem_wdata_sig  = r_mem_wdata;
    w_rf_dir_a_sig   = r_rf_dir_a;
    w_rf_dir_b_sig   = r_rf_dir_b;
    w_rf_we_sig      = 1'b0;
    w_rf_dir_w_sig   = r_rf_dir_w;
    w_rf_dato_w_sig  = r_rf_dato_w;
    w_alu_opcode_sig = OP_NOP;
    w_detenido_sig   = r_detenido;
    w_ilegal_sig     = 1'b0;

    unique case (r_estado)
      EST_FETCH: begin
        if (!r_mem_req) begin
          // first fetch after reset: raise the request
          w_mem_req_sig   = 1'b1;
          w_mem_we_sig    = 1'b0;
          w_mem_addr_sig  = r_pc;
          w_mem_wdata_sig = '0;
        end else if (mem_ack) begin
          w_ir_sig      = instr_t'(mem_rdata[31:0]);
          w_pc_sig      = w_pc_mas1;
          w_mem_req_sig = 1'b0;
          w_estado_sig  = EST_DECODE;
        end
      end

      EST_DECODE: begin
        w_rf_dir_a_sig = r_ir.ra;
        w_rf_dir_b_sig = r_ir.rb;
        if (w_clase == CL_ALU) begin
          w_alu_opcode_sig = r_ir.op;
        end
        w_estado_sig = EST_EXECUTE;
      end

      EST_EXECUTE: begin
        w_estado_sig = EST_FETCH;
        unique case (w_clase)
          CL_ALU: begin
            w_rf_we_sig     = 1'b1;
            w_rf_dir_w_sig  = r_ir.rd;
            w_rf_dato_w_sig = alu_resultado;
            w_banderas_sig  = {alu_C, alu_S,
                               alu_O, alu_Z};
          end
          CL_SALTO: begin
            if (w_incond || r_banderas[w_sel]) begin
              w_pc_sig = w_imm_ext;
            end
          end
          CL_MEM_LD, CL_MEM_ST: begin
            w_estado_sig    = EST_MEM;
            w_mem_req_sig   = 1'b1;
            w_mem_we_sig    = (w_clase == CL_MEM_ST);
            w_mem_addr_sig  = w_imm_ext;
            w_mem_wdata_sig = (w_clase == CL_MEM_ST) ?
                              rf_dato_a : '0;
          end
          CL_HLT: begin
            w_estado_sig   = EST_HALT;
            w_detenido_sig = 1'b1;
          end
          CL_ILEGAL: w_ilegal_sig = 1'b1;
          CL_NOP:    ;
          default:   ;
        endcase
        if (w_estado_sig == EST_FETCH) begin
          w_mem_req_sig   = 1'b1;
          w_mem_we_sig    = 1'b0;
          w_mem_addr_sig  = w_pc_sig;
          w_mem_wdata_sig = '0;
        end
      end

      EST_MEM: begin
        if (mem_ack) begin
          if (!r_mem_we) begin
            w_rf_we_sig     = 1'b1;
            w_rf_dir_w_sig  = r_ir.rd;
            w_rf_dato_w_sig = mem_rdata;
          end
          w_estado_sig    = EST_FETCH;
          w_mem_req_sig   = 1'b1;
          w_mem_we_sig    = 1'b0;
          w_mem_addr_sig  = r_pc;
          w_mem_wdata_sig = '0;
        end
      end

      EST_HALT: ;

      default: begin
        w_estado_sig  = EST_FETCH;
        w_mem_req_sig = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_estado     <= EST_FETCH;
      r_ir         <= '0;
      r_pc         <= PC_INICIO;
      r_banderas   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rf_dir_a   <= '0;
      r_rf_dir_b   <= '0;
      r_rf_we      <= 1'b0;
      r_rf_dir_w   <= '0;
      r_rf_dato_w  <= '0;
      r_alu_opcode <= OP_NOP;
      r_detenido   <= 1'b0;
      r_ilegal     <= 1'b0;
    end else begin
      r_estado     <= w_estado_sig;
      r_ir         <= w_ir_sig;
      r_pc         <= w_pc_sig;
      r_banderas   <= w_banderas_sig;
      r_mem_req    <= w_mem_req_sig;
      r_mem_we     <= w_mem_we_sig;
      r_mem_addr   <= w_mem_addr_sig;
      r_mem_wdata  <= w_mem_wdata_sig;
      r_rf_dir_a   <= w_rf_dir_a_sig;
      r_rf_dir_b   <= w_rf_dir_b_sig;
      r_rf_we      <= w_rf_we_sig;
      r_rf_dir_w   <= w_rf_dir_w_sig;
      r_rf_dato_w  <= w_rf_dato_w_sig;
      r_alu_opcode <= w_alu_opcode_sig;
      r_detenido   <= w_detenido_sig;
      r_ilegal     <= w_ilegal_sig;
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign rf_dir_a   = r_rf_dir_a;
  assign rf_dir_b   = r_rf_dir_b;
  assign rf_we      = r_rf_we;
  assign rf_dir_w   = r_rf_dir_w;
  assign rf_dato_w  = r_rf_dato_w;
  assign alu_opcode = r_alu_opcode;
  assign banderas   = r_banderas;
  assign pc         = r_pc;
  assign detenido   = r_detenido;
  assign ilegal     = r_ilegal;

endmodule

// File: tb/tb_unidad_control.sv
// tb_unidad_control: directed programs with an event scoreboard
// fed by the stimulus and drained by a negedge monitor.
module tb_unidad_control;

  localparam logic [4:0] T_NOP = 5'h00;
  localparam logic [4:0] T_ADD = 5'h06;
  localparam logic [4:0] T_SUB = 5'h07;
  localparam logic [4:0] T_MUL = 5'h08;
  localparam logic [4:0] T_JZ  = 5'h14;
  localparam logic [4:0] T_LD  = 5'h18;
  localparam logic [4:0] T_STR = 5'h19;
  localparam logic [4:0] T_HLT = 5'h1F;

  localparam int EV_RD  = 0;
  localparam int EV_ST  = 1;
  localparam int EV_WR  = 2;
  localparam int EV_ILG = 3;

  typedef struct {
    int          tipo;
    logic [15:0] dir;
    logic [31:0] dato;
    int          dt;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  rf_dir_a, rf_dir_b, rf_dir_w;
  logic [31:0] rf_dato_a, rf_dato_w;
  logic        rf_we;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_resultado;
  logic        alu_C, alu_S, alu_O, alu_Z;
  logic [3:0]  banderas;
  logic [15:0] pc;
  logic        detenido, ilegal;

  logic [31:0] mem  [0:255];
  logic [31:0] regs [0:15];
  int          espera = 0;
  int          cnt = 0;
  int          ciclo = 0;
  int          ultimo_rd = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          vigilar = 1'b0;
  bit          vio_we = 1'b0;
  ev_t         cola [$];

  unidad_control #(
    .BITS_DATA (32),
    .ANCHO_DIR (16),
    .PC_INICIO (16'hFFFF)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .rf_dir_a      (rf_dir_a),
    .rf_dir_b      (rf_dir_b),
    .rf_dato_a     (rf_dato_a),
    .rf_we         (rf_we),
    .rf_dir_w      (rf_dir_w),
    .rf_dato_w     (rf_dato_w),
    .alu_opcode    (alu_opcode),
    .alu_resultado (alu_resultado),
    .alu_C         (alu_C),
    .alu_S         (alu_S),
    .alu_O         (alu_O),
    .alu_Z         (alu_Z),
    .banderas      (banderas),
    .pc            (pc),
    .detenido      (detenido),
    .ilegal        (ilegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ciclo <= ciclo + 1;

  // Memory: data window 0x10-0x1F has 'espera' wait cycles
  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_ack = mem_req &&
    (cnt == ((mem_addr[15:4] == 12'h001) ? espera : 0));

  always @(posedge clk) begin
    if (!reset_n || !mem_req || mem_ack) cnt <= 0;
    else cnt <= cnt + 1;
    if (mem_req && mem_ack && mem_we)
      mem[mem_addr[7:0]] <= mem_wdata;
  end

  // Register file
  assign rf_dato_a = regs[rf_dir_a];
  always @(posedge clk) if (rf_we) regs[rf_dir_w] <= rf_dato_w;

  // Reference ALU
  always_comb begin
    logic [32:0] t;
    logic [31:0] a, b;
    a = regs[rf_dir_a];
    b = regs[rf_dir_b];
    t = '0;
    alu_O = 1'b0;
    case (alu_opcode)
      5'h01: t = {1'b0, ~a};
      5'h02: t = {1'b0, a & b};
      5'h03: t = {1'b0, a | b};
      5'h05: t = {1'b0, -a};
      T_ADD: begin
        t = {1'b0, a} + {1'b0, b};
        alu_O = (a[31] == b[31]) && (t[31] != a[31]);
      end
      T_SUB: begin
        t = {1'b0, a} - {1'b0, b};
        alu_O = (a[31] != b[31]) && (t[31] != a[31]);
      end
      default: t = '0;
    endcase
    alu_resultado = t[31:0];
    alu_C = t[32];
    alu_S = t[31];
    alu_Z = (t[31:0] == 32'h0);
  end

  function automatic logic [31:0] enc(
    input logic [4:0] op, input logic [3:0] rd,
    input logic [3:0] ra, input logic [3:0] rb,
    input logic [14:0] imm);
    return {op, rd, ra, rb, imm};
  endfunction

  task automatic esperar_ev(input int tipo,
    input logic [15:0] dir, input logic [31:0] dato,
    input int dt);
    ev_t e;
    e.tipo = tipo; e.dir = dir; e.dato = dato; e.dt = dt;
    cola.push_back(e);
  endtask

  task automatic verif(input int tipo,
    input logic [15:0] dir, input logic [31:0] dato,
    input int dt);
    ev_t e;
    n_checks++;
    if (cola.size() == 0) begin
      n_errors++;
      $display("FAIL evento: unexpected type %0d dir=%h dato=%h",
               tipo, dir, dato);
    end else begin
      e = cola.pop_front();
      if (e.tipo != tipo || e.dir != dir || e.dato != dato ||
          (e.dt >= 0 && e.dt != dt)) begin
        n_errors++;
        $display("FAIL evento: got t=%0d dir=%h dato=%h dt=%0d, required t=%0d dir=%h dato=%h dt=%0d",
                 tipo, dir, dato, dt, e.tipo, e.dir, e.dato, e.dt);
      end
    end
  endtask

  // Monitor: order within a cycle matches program order
  always @(negedge clk) begin
    if (reset_n) begin
      if (rf_we) verif(EV_WR, {12'h0, rf_dir_w}, rf_dato_w, -1);
      if (ilegal) verif(EV_ILG, 16'h0, 32'h0, -1);
      if (mem_req && mem_ack) begin
        if (mem_we) verif(EV_ST, mem_addr, mem_wdata, -1);
        else begin
          verif(EV_RD, mem_addr, {28'h0, banderas},
                ciclo - ultimo_rd);
          ultimo_rd = ciclo;
        end
      end
    end
    if (vigilar && rf_we) vio_we = 1'b1;
  end

  task automatic chk(input string nombre,
    input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", nombre, act, exp);
    end
  endtask

  task automatic esperar_vacio(input string nombre);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      if (cola.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: %0d events pending, required 0",
               nombre, cola.size());
      cola.delete();
    end
  endtask

  task automatic reiniciar();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    // ---- program 1: ALU, flags, MUL, JZ, wrap, HLT ----
    reiniciar();
    chk("reset pc/banderas", {pc, banderas}, {16'hFFFF, 4'h0});
    chk("reset ctrl",
        {mem_req, mem_we, rf_we, detenido, ilegal, alu_opcode},
        {5'b0, 5'h00});
    chk("reset buses",
        {mem_addr, rf_dir_a, rf_dir_b, rf_dir_w},
        {16'h0, 4'h0, 4'h0, 4'h0});
    chk("reset datos", {mem_wdata, rf_dato_w}, 64'h0);
    espera = 0;
    regs[2] = 32'h7FFF_FFFF;
    regs[3] = 32'h0000_0001;
    mem[8'hFF] = enc(T_NOP, 0, 0, 0, 0);
    mem[8'h00] = enc(T_ADD, 1, 2, 3, 0);
    mem[8'h01] = enc(T_SUB, 5, 3, 3, 0);
    mem[8'h02] = enc(T_MUL, 7, 3, 3, 0);
    mem[8'h03] = enc(T_JZ, 0, 0, 0, 15'h0040);
    mem[8'h40] = enc(T_ADD, 6, 3, 3, 0);
    mem[8'h41] = enc(T_JZ, 0, 0, 0, 15'h0060);
    mem[8'h42] = enc(T_HLT, 0, 0, 0, 0);
    esperar_ev(EV_RD, 16'hFFFF, 32'h0, -1);
    esperar_ev(EV_RD, 16'h0000, 32'h0, 3);
    esperar_ev(EV_WR, 16'h1, 32'h8000_0000, -1);
    esperar_ev(EV_RD, 16'h0001, 32'h6, 3);
    esperar_ev(EV_WR, 16'h5, 32'h0, -1);
    esperar_ev(EV_RD, 16'h0002, 32'h1, 3);
    esperar_ev(EV_ILG, 16'h0, 32'h0, -1);
    esperar_ev(EV_RD, 16'h0003, 32'h1, 3);
    esperar_ev(EV_RD, 16'h0040, 32'h1, 3);
    esperar_ev(EV_WR, 16'h6, 32'h2, -1);
    esperar_ev(EV_RD, 16'h0041, 32'h0, 3);
    esperar_ev(EV_RD, 16'h0042, 32'h0, 3);
    reset_n = 1'b1;
    @(negedge clk);
    chk("first req", {mem_req, mem_addr}, {1'b1, 16'hFFFF});
    esperar_vacio("prog1");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt", {detenido, mem_req}, 2'b10);
    end
    chk("r7 untouched", regs[7], 32'h0);
    chk("r1", regs[1], 32'h8000_0000);

    // ---- program 2: LD/STR with 2 wait cycles ----
    reiniciar();
    espera = 2;
    mem[8'hFF] = enc(T_NOP, 0, 0, 0, 0);
    mem[8'h00] = enc(T_LD, 4, 0, 0, 15'h0010);
    mem[8'h01] = enc(T_STR, 0, 4, 0, 15'h0011);
    mem[8'h02] = enc(T_HLT, 0, 0, 0, 0);
    mem[8'h10] = 32'hDEAD_BEEF;
    esperar_ev(EV_RD, 16'hFFFF, 32'h0, -1);
    esperar_ev(EV_RD, 16'h0000, 32'h0, 3);
    esperar_ev(EV_RD, 16'h0010, 32'h0, 5);
    esperar_ev(EV_WR, 16'h4, 32'hDEAD_BEEF, -1);
    esperar_ev(EV_RD, 16'h0001, 32'h0, 1);
    esperar_ev(EV_ST, 16'h0011, 32'hDEAD_BEEF, -1);
    esperar_ev(EV_RD, 16'h0002, 32'h0, 6);
    reset_n = 1'b1;
    esperar_vacio("prog2");
    repeat (4) @(negedge clk);
    chk("mem[11]", mem[8'h11], 32'hDEAD_BEEF);
    chk("r4", regs[4], 32'hDEAD_BEEF);
    chk("halt2", {detenido, mem_req}, 2'b10);

    // ---- program 3: reset while LD is pending ----
    reiniciar();
    espera = 1000;
    mem[8'hFF] = enc(T_NOP, 0, 0, 0, 0);
    mem[8'h00] = enc(T_LD, 8, 0, 0, 15'h0012);
    esperar_ev(EV_RD, 16'hFFFF, 32'h0, -1);
    esperar_ev(EV_RD, 16'h0000, 32'h0, 3);
    vigilar = 1'b1;
    reset_n = 1'b1;
    esperar_vacio("prog3");
    begin
      bit vis;
      vis = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (mem_req && mem_addr == 16'h0012) begin
          vis = 1'b1;
          break;
        end
      end
      chk("LD pending", {63'h0, vis}, 64'h1);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort req/pc", {mem_req, rf_we, pc},
        {1'b0, 1'b0, 16'hFFFF});
    esperar_ev(EV_RD, 16'hFFFF, 32'h0, -1);
    esperar_ev(EV_RD, 16'h0000, 32'h0, 3);
    reset_n = 1'b1;
    esperar_vacio("prog3 restart");
    repeat (5) @(negedge clk);
    vigilar = 1'b0;
    chk("no rf_we", {63'h0, vio_we}, 64'h0);
    chk("r8", regs[8], 32'h0);
    reiniciar();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
